param_register_bank: RTL and testbench

//  Parametrised general-purpose register file for the RISC datapath: N x DATA_W regs,
//  two registered read ports, one write port, write-to-read bypass, optional

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_read_port.sv | 37 +++
 rtl/param_register_bank.sv | 121 ++++++++++++
 tb/tb_param_register_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults for the general-purpose register file.
package rf_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF  = 4;
    localparam int unsigned OUT_W_DEF   = 16;
    localparam int unsigned OUT_IDX_DEF = 1;
    localparam int unsigned REG_ZERO    = 0;

endpackage

// File: rtl/rf_read_port.sv
// One read port: index decode, write-data bypass and busy (pending-write) check.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned NREGS   = 2 ** ADDR_W,
    parameter int unsigned ZERO_R0 = 1,
    parameter int unsigned BYPASS  = 1
) (
    input  logic [ADDR_W-1:0]             src_i,
    input  logic                          wr_en_i,
    input  logic [ADDR_W-1:0]             dst_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic [NREGS-1:0][DATA_W-1:0]  regs_i,
    input  logic [NREGS-1:0]              busy_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          hit_o
);

    logic fwd;

    // A same-cycle write to the source both supplies the data and resolves the pending write.
    assign fwd = (BYPASS != 0) && wr_en_i && (dst_i == src_i);

    always_comb begin
        hit_o = busy_i[src_i] && !fwd;
        if ((ZERO_R0 != 0) && (src_i == ADDR_W'(REG_ZERO))) begin
            data_o = '0;
        end else if (fwd) begin
            data_o = wdata_i;
        end else begin
            data_o = regs_i[src_i];
        end
    end

endmodule

// File: rtl/param_register_bank.sv
// Register file: two registered read ports, one write port, busy scoreboard with read
// stall, optional hardwired-zero r0 and a mirrored output of one register.
module param_register_bank
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter int unsigned OUT_IDX = OUT_IDX_DEF,
    parameter int unsigned ZERO_R0 = 1,
    parameter int unsigned BYPASS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] dst,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_dst,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              rd_valid,
    output logic              stall,
    output logic [OUT_W-1:0]  out
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0]             busy_q, busy_d;
    logic [DATA_W-1:0]            a_q, b_q;
    logic                         rd_valid_q;
    logic [OUT_W-1:0]             out_q;

    logic [DATA_W-1:0] data1, data2;
    logic              hit1, hit2;
    logic              wr_ok, rsv_ok, rd_ok;

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NREGS   (NREGS),
        .ZERO_R0 (ZERO_R0),
        .BYPASS  (BYPASS)
    ) u_port_a (
        .src_i   (src1),
        .wr_en_i (wr_en),
        .dst_i   (dst),
        .wdata_i (wdata),
        .regs_i  (regs_q),
        .busy_i  (busy_q),
        .data_o  (data1),
        .hit_o   (hit1)
    );

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NREGS   (NREGS),
        .ZERO_R0 (ZERO_R0),
        .BYPASS  (BYPASS)
    ) u_port_b (
        .src_i   (src2),
        .wr_en_i (wr_en),
        .dst_i   (dst),
        .wdata_i (wdata),
        .regs_i  (regs_q),
        .busy_i  (busy_q),
        .data_o  (data2),
        .hit_o   (hit2)
    );

    assign wr_ok  = wr_en && !((ZERO_R0 != 0) && (dst == ADDR_W'(REG_ZERO)));
    assign rsv_ok = rsv_en && !((ZERO_R0 != 0) && (rsv_dst == ADDR_W'(REG_ZERO)));
    assign stall  = rd_en && (hit1 || hit2);
    assign rd_ok  = rd_en && !stall;

    // Reservation is applied after the write clear so a new reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[dst] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q     <= '0;
            busy_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_valid_q <= 1'b0;
            out_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            rd_valid_q <= rd_ok;
            if (wr_ok) begin
                regs_q[dst] <= wdata;
                if (dst == ADDR_W'(OUT_IDX)) begin
                    out_q <= wdata[OUT_W-1:0];
                end
            end
            if (rd_ok) begin
                a_q <= data1;
                b_q <= data2;
            end
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign rd_valid = rd_valid_q;
    assign out      = out_q;

endmodule

// File: tb/tb_param_register_bank.sv
// Directed bench for param_register_bank; a second instance runs with BYPASS=0.
module tb_param_register_bank;

    logic        clk = 1'b0;
    logic        reset, rd_en, wr_en, rsv_en;
    logic [3:0]  src1, src2, dst, rsv_dst;
    logic [31:0] wdata;
    logic [31:0] a, b, a_nb, b_nb;
    logic        rd_valid, stall, rd_valid_nb, stall_nb;
    logic [15:0] out, out_nb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    param_register_bank #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .src1(src1), .src2(src2),
        .wr_en(wr_en), .dst(dst), .wdata(wdata), .rsv_en(rsv_en), .rsv_dst(rsv_dst),
        .a(a), .b(b), .rd_valid(rd_valid), .stall(stall), .out(out)
    );

    param_register_bank #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_en(rd_en), .src1(src1), .src2(src2),
        .wr_en(wr_en), .dst(dst), .wdata(wdata), .rsv_en(rsv_en), .rsv_dst(rsv_dst),
        .a(a_nb), .b(b_nb), .rd_valid(rd_valid_nb), .stall(stall_nb), .out(out_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 0; wr_en = 0; rsv_en = 0;
        src1 = 0; src2 = 0; dst = 0; rsv_dst = 0; wdata = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        n_checks++; if (a !== 32'h0) begin n_fail++; $display("FAIL reset_a got %h exp 0", a); end
        n_checks++; if (b !== 32'h0) begin n_fail++; $display("FAIL reset_b got %h exp 0", b); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdv got %b exp 0", rd_valid); end
        n_checks++; if (out !== 16'h0) begin n_fail++; $display("FAIL reset_out got %h exp 0", out); end
        rd_en = 1; src1 = 3; src2 = 7;
        tick();
        idle();
        n_checks++; if (a !== 32'h0 || b !== 32'h0) begin n_fail++; $display("FAIL first_read got a=%h b=%h exp 0 0", a, b); end
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL first_rdv got %b exp 1", rd_valid); end
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rdv_pulse got %b exp 0", rd_valid); end
    endtask

    task automatic test_write_read();
        wr_en = 1; dst = 5; wdata = 32'hDEAD_BEEF;
        tick();
        idle();
        rd_en = 1; src1 = 5; src2 = 3;
        tick();
        n_checks++; if (a !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_then_rd got %h exp deadbeef", a); end
        n_checks++; if (b !== 32'h0) begin n_fail++; $display("FAIL rd_other got %h exp 0", b); end
        wr_en = 1; dst = 5; wdata = 32'hCAFE_F00D;
        rd_en = 1; src1 = 5;
        tick();
        idle();
        n_checks++; if (a !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bypass got %h exp cafef00d", a); end
        n_checks++; if (a_nb !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL no_bypass got %h exp deadbeef", a_nb); end
    endtask

    task automatic test_zero_reg();
        wr_en = 1; dst = 0; wdata = 32'h1234;
        tick();
        idle();
        rd_en = 1; src1 = 0; src2 = 5;
        tick();
        n_checks++; if (a !== 32'h0) begin n_fail++; $display("FAIL r0_read got %h exp 0", a); end
        n_checks++; if (b !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL r5_read got %h exp cafef00d", b); end
        idle();
        rsv_en = 1; rsv_dst = 0;
        tick();
        idle();
        rd_en = 1; src1 = 0; src2 = 0; wr_en = 1; dst = 0; wdata = 32'h5555;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %b exp 0", stall); end
        tick();
        idle();
        n_checks++; if (a !== 32'h0 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL r0_bypass got a=%h v=%b exp 0 1", a, rd_valid); end
    endtask

    task automatic test_out_mirror();
        wr_en = 1; dst = 1; wdata = 32'hABCD_5678;
        tick();
        n_checks++; if (out !== 16'h5678) begin n_fail++; $display("FAIL out_mirror got %h exp 5678", out); end
        dst = 2; wdata = 32'h1111_2222;
        tick();
        idle();
        n_checks++; if (out !== 16'h5678) begin n_fail++; $display("FAIL out_hold got %h exp 5678", out); end
        rd_en = 1; src1 = 1; src2 = 2;
        tick();
        idle();
        n_checks++; if (a !== 32'hABCD_5678 || b !== 32'h1111_2222) begin n_fail++; $display("FAIL r1_r2 got a=%h b=%h exp abcd5678 11112222", a, b); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1; rsv_dst = 4;
        tick();
        idle();
        rd_en = 1; src1 = 1; src2 = 4;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL busy_stall got %b exp 1", stall); end
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_rdv got %b exp 0", rd_valid); end
        n_checks++; if (a !== 32'hABCD_5678 || b !== 32'h1111_2222) begin n_fail++; $display("FAIL stall_hold got a=%h b=%h exp abcd5678 11112222", a, b); end
        wr_en = 1; dst = 4; wdata = 32'd9;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wr_unstall got %b exp 0", stall); end
        n_checks++; if (stall_nb !== 1'b1) begin n_fail++; $display("FAIL nb_stall got %b exp 1", stall_nb); end
        tick();
        idle();
        n_checks++; if (b !== 32'd9 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL wr_bypass got b=%h v=%b exp 9 1", b, rd_valid); end
        rsv_en = 1; rsv_dst = 6; wr_en = 1; dst = 6; wdata = 32'h66;
        tick();
        idle();
        rd_en = 1; src1 = 6; src2 = 0;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rsv_wins got %b exp 1", stall); end
        rd_en = 0; rsv_en = 1; rsv_dst = 6;
        tick();
        idle();
        rd_en = 1; src1 = 2; src2 = 6;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rsv_again got %b exp 1", stall); end
        src2 = 4;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r4_cleared got %b exp 0", stall); end
    endtask

    task automatic test_reset_mid();
        idle();
        rd_en = 1; src1 = 1; src2 = 2;
        tick();
        wr_en = 1; dst = 3; wdata = 32'h77;
        rsv_en = 1; rsv_dst = 7;
        reset = 1;
        tick();
        reset = 0;
        idle();
        n_checks++; if (a !== 32'h0 || b !== 32'h0) begin n_fail++; $display("FAIL mid_reset_ab got a=%h b=%h exp 0 0", a, b); end
        n_checks++; if (rd_valid !== 1'b0 || out !== 16'h0) begin n_fail++; $display("FAIL mid_reset_vo got v=%b out=%h exp 0 0", rd_valid, out); end
        rd_en = 1; src1 = 6; src2 = 7;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL busy_cleared got %b exp 0", stall); end
        tick();
        n_checks++; if (a !== 32'h0 || b !== 32'h0 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_rd got a=%h b=%h v=%b exp 0 0 1", a, b, rd_valid); end
        src1 = 1; src2 = 3;
        tick();
        idle();
        n_checks++; if (a !== 32'h0 || b !== 32'h0) begin n_fail++; $display("FAIL regs_cleared got a=%h b=%h exp 0 0", a, b); end
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_out_mirror();
        test_scoreboard();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
